// File: rtl/pipe_stage_elastic.sv
// -----------------------------------------------------------------------------
// pipe_stage_elastic
//
// Elastic pipeline register placed between two stages of the RV32I core
// (primary use: decode -> execute). It holds up to two entries (MAIN + SKID)
// behind a valid/ready handshake, so downstream back-pressure never has to be
// propagated combinationally upstream. A synchronous flush kills every held
// entry and any entry offered in the same cycle. When no entry is valid the
// stage presents a canonical bubble: control bits zero, instruction = NOP.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-low
//   flush      discard held entries and the entry offered this cycle
//   in_valid   upstream offers an entry
//   in_ready   stage can accept (depends on state only)
//   in_ctrl    control bundle            (CTRL_W)
//   in_data    datapath bundle           (DATA_W)
//   in_pc      instruction address       (XLEN)
//   in_instr   instruction word          (XLEN)
//   out_valid  head entry valid
//   out_ready  downstream consumes the head
//   out_ctrl   head control, 0 in a bubble
//   out_data   head datapath bundle (MAIN contents, not masked)
//   out_pc     head PC (MAIN contents, not masked)
//   out_instr  head instruction, NOP_INSTR in a bubble
//   occupancy  number of entries held (0..2)
// -----------------------------------------------------------------------------
module pipe_stage_elastic #(
  parameter int unsigned            CTRL_W    = 12,
  parameter int unsigned            DATA_W    = 106,
  parameter int unsigned            XLEN      = 32,
  parameter logic [XLEN-1:0]        NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_instr,
  output logic [1:0]        occupancy
);

  // Encoding equals the number of held entries, so occupancy is the state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   instr;
  } slot_t;

  state_t state;
  slot_t  main_q;
  slot_t  skid_q;
  slot_t  in_slot;

  logic   accept;
  logic   pop;

  assign in_slot = '{ctrl: in_ctrl, data: in_data, pc: in_pc, instr: in_instr};

  // Both handshake qualifiers come from registered state only, so there is
  // no combinational out_ready -> in_ready or in_* -> out_* path.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign occupancy = state;

  assign accept = in_valid & in_ready & ~flush;
  assign pop    = out_valid & out_ready;

  // Bubble masking: consumers see a harmless NOP with all control cleared.
  assign out_ctrl  = out_valid ? main_q.ctrl  : '0;
  assign out_instr = out_valid ? main_q.instr : NOP_INSTR;
  assign out_data  = main_q.data;
  assign out_pc    = main_q.pc;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would make MAIN <- SKID order-
  // dependent.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= EMPTY;
      // NOTE: the payload slots are reset too (not just the state) so that
      // out_data/out_pc are deterministic from the first cycle after reset.
      main_q <= '{ctrl: '0, data: '0, pc: '0, instr: NOP_INSTR};
      skid_q <= '{ctrl: '0, data: '0, pc: '0, instr: NOP_INSTR};
    end else if (flush) begin
      // Payloads are left in place; out_valid = 0 masks them.
      state <= EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state  <= ONE;
            main_q <= in_slot;
          end
        end
        ONE: begin
          if (accept && !pop) begin
            state  <= FULL;
            skid_q <= in_slot;
          end else if (accept && pop) begin
            main_q <= in_slot;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only a pop can happen.
          if (pop) begin
            state  <= ONE;
            main_q <= skid_q;
          end
        end
        // NOTE: the unused encoding recovers to EMPTY instead of sticking.
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_elastic
//
// Directed scenarios followed by randomized traffic. The reference model is a
// FIFO queue of at most two entries plus the value last seen at the head.
// Inputs are driven on the falling edge, outputs are compared 1 ns after the
// rising edge.
// -----------------------------------------------------------------------------
module tb_pipe_stage_elastic;

  localparam int unsigned   CTRL_W = 12;
  localparam int unsigned   DATA_W = 106;
  localparam int unsigned   XLEN   = 32;
  localparam logic [31:0]   NOP    = 32'h0000_0013;

  typedef struct {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   instr;
  } entry_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic [XLEN-1:0]   in_pc = '0;
  logic [XLEN-1:0]   in_instr = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [XLEN-1:0]   out_pc;
  logic [XLEN-1:0]   out_instr;
  logic [1:0]        occupancy;

  pipe_stage_elastic dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctrl  (in_ctrl),
    .in_data  (in_data),
    .in_pc    (in_pc),
    .in_instr (in_instr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl (out_ctrl),
    .out_data (out_data),
    .out_pc   (out_pc),
    .out_instr(out_instr),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     passed = 0;
  int     failed = 0;

  entry_t q[$];
  entry_t last_head;

  function automatic entry_t reset_entry();
    entry_t e;
    e.ctrl = '0; e.data = '0; e.pc = '0; e.instr = NOP;
    return e;
  endfunction

  function automatic entry_t mk(input logic [31:0] pc);
    entry_t e;
    logic [127:0] wide;
    wide    = {$urandom, $urandom, $urandom, $urandom};
    e.ctrl  = CTRL_W'($urandom);
    e.data  = wide[DATA_W-1:0];
    e.pc    = pc;
    e.instr = $urandom;
    return e;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model.
  task automatic check_all(input string tag);
    entry_t head;
    bit     v;
    v    = (q.size() != 0);
    head = v ? q[0] : last_head;
    check({tag, ".out_valid"}, 128'(out_valid), 128'(v));
    check({tag, ".in_ready"},  128'(in_ready),  128'(q.size() < 2));
    check({tag, ".occupancy"}, 128'(occupancy), 128'(q.size()));
    check({tag, ".out_ctrl"},  128'(out_ctrl),  v ? 128'(head.ctrl) : 128'(0));
    check({tag, ".out_instr"}, 128'(out_instr), v ? 128'(head.instr) : 128'(NOP));
    check({tag, ".out_pc"},    128'(out_pc),    128'(head.pc));
    check({tag, ".out_data"},  128'(out_data),  128'(head.data));
  endtask

  // One clock: drive inputs, advance the model on the edge, compare after.
  task automatic step(input string tag, input logic r, input logic f,
                      input logic iv, input logic orr, input entry_t e);
    bit exp_ready, exp_valid, acc, pp;
    @(negedge clk);
    rst = r; flush = f; in_valid = iv; out_ready = orr;
    in_ctrl = e.ctrl; in_data = e.data; in_pc = e.pc; in_instr = e.instr;
    @(posedge clk);
    exp_ready = (q.size() < 2);
    exp_valid = (q.size() != 0);
    acc = r && !f && iv && exp_ready;
    pp  = exp_valid && orr;
    if (!r) begin
      q.delete();
      last_head = reset_entry();
    end else if (f) begin
      q.delete();
    end else begin
      if (pp)  void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    if (q.size() != 0) last_head = q[0];
    #1;
    check_all(tag);
  endtask

  initial begin
    entry_t e;
    entry_t ones;
    last_head = reset_entry();

    // Reset.
    step("reset0", 1'b0, 1'b0, 1'b1, 1'b0, mk(32'hdead_0000));
    step("reset1", 1'b0, 1'b0, 1'b0, 1'b0, mk(32'h0));
    check("reset.out_instr_nop", 128'(out_instr), 128'(NOP));

    // Streaming at full throughput.
    for (int i = 0; i < 4; i++) begin
      step("stream", 1'b1, 1'b0, 1'b1, 1'b1, mk(32'(i * 4)));
      check("stream.pc", 128'(out_pc), 128'(i * 4));
      check("stream.occ", 128'(occupancy), 128'(1));
    end
    step("stream_drain", 1'b1, 1'b0, 1'b0, 1'b1, mk(32'h0));

    // Back-pressure: 0x18 held upstream until in_ready returns.
    step("bp10", 1'b1, 1'b0, 1'b1, 1'b1, mk(32'h10));
    step("bp14", 1'b1, 1'b0, 1'b1, 1'b0, mk(32'h14));
    check("bp.in_ready_low", 128'(in_ready), 128'(0));
    e = mk(32'h18);
    step("bp18_held", 1'b1, 1'b0, 1'b1, 1'b0, e);
    step("bp_rel0", 1'b1, 1'b0, 1'b1, 1'b1, e);
    check("bp.drain14", 128'(out_pc), 128'(32'h14));
    step("bp_rel1", 1'b1, 1'b0, 1'b1, 1'b1, e);
    check("bp.drain18", 128'(out_pc), 128'(32'h18));
    step("bp_empty", 1'b1, 1'b0, 1'b0, 1'b1, mk(32'h0));

    // Flush while FULL with an offered entry.
    step("fl_a", 1'b1, 1'b0, 1'b1, 1'b0, mk(32'h30));
    step("fl_b", 1'b1, 1'b0, 1'b1, 1'b0, mk(32'h34));
    step("flush", 1'b1, 1'b1, 1'b1, 1'b0, mk(32'h20));
    check("flush.valid", 128'(out_valid), 128'(0));
    check("flush.instr", 128'(out_instr), 128'(NOP));
    check("flush.ready", 128'(in_ready), 128'(1));
    step("post_flush", 1'b1, 1'b0, 1'b0, 1'b1, mk(32'h0));

    // Simultaneous pop + accept in ONE.
    step("pa40", 1'b1, 1'b0, 1'b1, 1'b0, mk(32'h40));
    step("pa44", 1'b1, 1'b0, 1'b1, 1'b1, mk(32'h44));
    check("popacc.pc", 128'(out_pc), 128'(32'h44));
    check("popacc.occ", 128'(occupancy), 128'(1));

    // Reset mid-stream while FULL.
    step("rs_fill", 1'b1, 1'b0, 1'b1, 1'b0, mk(32'h48));
    step("rs_reset", 1'b0, 1'b0, 1'b1, 1'b0, mk(32'h4c));
    check("rst_mid.pc", 128'(out_pc), 128'(0));
    step("rs_first", 1'b1, 1'b0, 1'b1, 1'b0, mk(32'h50));
    check("rst_mid.first", 128'(out_pc), 128'(32'h50));
    step("rs_drain", 1'b1, 1'b0, 1'b0, 1'b1, mk(32'h0));

    // Bubble masking with all-ones control offered but not valid.
    ones = mk(32'h60);
    ones.ctrl = '1;
    for (int i = 0; i < 5; i++) begin
      step("bubble", 1'b1, 1'b0, 1'b0, 1'b1, ones);
      check("bubble.ctrl", 128'(out_ctrl), 128'(0));
    end

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic r, f, iv, orr;
      r   = ($urandom_range(0, 63) != 0);
      f   = ($urandom_range(0, 15) == 0);
      iv  = ($urandom_range(0, 3) != 0);
      orr = ($urandom_range(0, 2) != 0);
      step("rand", r, f, iv, orr, mk($urandom));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
